sms_sbox_share_arb: RTL and testbench
=====================================

// Module: sms_sbox_share_arb
// PURPOSE
// - Shares one combinational 6-bit power-map S-box core (GF(2^6) x -> x^52) between N_REQ requesters.
// - Round-robin arbitration, valid/ready handshakes on every port.
// - One registered result stage; each result is tagged with the requester index.
// - Sits between the round-function lanes of the cipher datapath and a single S-box instance, saving area.
// PARAMETERS
// - N_REQ   4   number of requesters, 2..8
// - ID_W    2   requester-index width; must equal clog2(N_REQ)
// PORTS
// - clk        in   1          rising-edge clock; only clock
// - rst_n      in   1          synchronous, active-low reset
// - req_valid  in   N_REQ      per-requester operand valid
// - req_data   in   6*N_REQ    operands; requester i uses bits [6i+5:6i]
// - req_ready  out  N_REQ      one-hot grant/accept; combinational
// - rsp_valid  out  1          result valid
// - rsp_data   out  6          S-box output
// - rsp_id     out  ID_W       index of the requester that owns rsp_data
// - rsp_ready  in   1          consumer accepts result
// - busy       out  1          high when any req_valid is set or rsp_valid is set
// BEHAVIOUR
// - Reset (rst_n=0 at a clk edge): rsp_valid=0, rsp_data=0, rsp_id=0, rr_ptr=0.
//   - Any held result is discarded.
//   - req_ready is forced to 0 while rst_n=0.
// - Slot free condition: slot_free = !rsp_valid || rsp_ready.
// - Grant: when slot_free is high, grant goes to the first i with req_valid[i]=1, searching rr_ptr, rr_ptr+1, ... mod N_REQ.
//   - req_ready[g]=1 only for the granted g, and only when slot_free=1.
//   - Otherwise req_ready is all 0.
// - Transfer: req_valid[g] & req_ready[g]. On that edge:
//   - rsp_data <= SBOX(req_data[g]), rsp_id <= g, rsp_valid <= 1.
//   - rr_ptr <= (g+1) mod N_REQ.
// - Latency is 1 cycle from the accept edge to rsp_valid. Throughput is 1 result per cycle when rsp_ready is held high.
// - If rsp_valid & rsp_ready with no new transfer in the same cycle: rsp_valid <= 0. rsp_data and rsp_id hold their values.
// - Simultaneous drain and accept in one cycle: the new result replaces the old with no bubble. rsp_valid stays 1.
// - Backpressure: while rsp_valid & !rsp_ready, rsp_data and rsp_id are stable and req_ready is all 0.
// - Requester obligations:
//   - Once req_valid[i] is asserted it stays high and req_data[i] stays stable until accepted.
//   - The block never drops an asserted request.
// - Fairness: a requester that stays valid is granted within N_REQ accepted transfers.
// - rr_ptr is unchanged on cycles with no transfer.
// - Wrap-around: after a grant to N_REQ-1, rr_ptr returns to 0.
// - SBOX is the pure combinational power map.
//   - SBOX(0)=0 and SBOX(1)=1.
//   - All other values come from the team's golden 64-entry table.
// - Reset mid-operation: the in-flight result is lost. No response for it is ever produced.
// - No X on outputs after the first reset edge.
// STRUCTURE
// - Shared package sms_pkg holds:
//   - SBOX_W=6.
//   - The localparam golden S-box table, used by TB only.
//   - A function rr_next(ptr, N) for the pointer increment.
// - One sub-module: sms_rr_arbiter.
//   - Parameterised N_REQ.
//   - Inputs: req vector, rr_ptr, enable. Output: one-hot grant plus the encoded index.
//   - Purely combinational.
// - The S-box core is instantiated once, unchanged, fed by the mux selected by the granted index.
// - The top level holds the output register, rr_ptr and the handshake logic.
// TESTING
// - Reset: assert rst_n=0 with all req_valid=1. Required: rsp_valid=0, req_ready=0, busy=1, rr_ptr=0.
// - Single request: req_valid=4'b0010, req_data[1]=6'h01, rsp_ready=1. Required: req_ready=0010; next cycle rsp_valid=1, rsp_data=6'h01, rsp_id=1.
// - Round-robin sweep: all 4 valid, operands 0,1,2,3, rsp_ready=1. Required: ids 0,1,2,3,0,...; data matches the golden table; one result per cycle.
// - Backpressure: rsp_ready=0 for 5 cycles while a result is held. Required: rsp_data/rsp_id stable, req_ready=0; on release the next grant follows rr_ptr.
// - Exhaustive: every requester sends all 64 values with random valid/ready. Required: every response matches the golden table and tag; no loss, no duplicate; per-requester order preserved.
// - Mid-op reset: pulse rst_n=0 one cycle while rsp_valid=1, rsp_ready=0. Required: rsp_valid=0 next cycle; the held result never appears.

Source files
------------

// File: rtl/sms_pkg.sv
// Shared definitions for the S-box sharing arbiter: field width, field polynomial,
// pointer helper and the golden S-box table.
package sms_pkg;

  localparam int unsigned SBOX_W = 6;
  localparam int unsigned SBOX_N = 64;

  // Low part of the field polynomial x^6 + x + 1 (x^6 reduces to x + 1)
  localparam logic [SBOX_W-1:0] GF_RED = 6'h03;

  // Round-robin pointer increment with wrap at n
  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

  // Golden x^52 table built from discrete logs: for x = a^k, x^52 = a^(52k mod 63)
  function automatic logic [SBOX_N-1:0][SBOX_W-1:0] gen_golden();
    logic [SBOX_W-1:0]               alog [63];
    logic [SBOX_W-1:0]               a;
    logic [SBOX_N-1:0][SBOX_W-1:0]   t;
    a = 6'h01;
    for (int k = 0; k < 63; k++) begin
      alog[k] = a;
      a = {a[SBOX_W-2:0], 1'b0} ^ (a[SBOX_W-1] ? GF_RED : 6'h00);
    end
    t = '0;
    for (int k = 0; k < 63; k++) begin
      t[alog[k]] = alog[(52 * k) % 63];
    end
    return t;
  endfunction

  localparam logic [SBOX_N-1:0][SBOX_W-1:0] SBOX_GOLDEN = gen_golden();

endpackage

// File: rtl/sms_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr wins.
module sms_rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [ID_W-1:0]  ptr,
  input  logic             enable,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  idx
);

  logic        found;
  logic [31:0] cand;

  // Rotating priority search, then one-hot grant gated by enable
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = (32'(ptr) + 32'(k)) % 32'(N_REQ);
      if (!found && req[cand[ID_W-1:0]]) begin
        found = 1'b1;
        idx   = cand[ID_W-1:0];
      end
    end
    grant = (found && enable) ? (N_REQ'(1) << idx) : '0;
  end

endmodule

// File: rtl/sms_sbox_core.sv
// Combinational GF(2^6) power map y = x^52 (x^32 * x^16 * x^4).
module sms_sbox_core
  import sms_pkg::*;
(
  input  logic [SBOX_W-1:0] x,
  output logic [SBOX_W-1:0] y
);

  // Shift-and-add field multiply modulo x^6 + x + 1
  function automatic logic [SBOX_W-1:0] gf_mul(input logic [SBOX_W-1:0] a,
                                               input logic [SBOX_W-1:0] b);
    logic [SBOX_W-1:0] p;
    logic [SBOX_W-1:0] s;
    p = '0;
    s = a;
    for (int i = 0; i < int'(SBOX_W); i++) begin
      if (b[i]) p = p ^ s;
      s = {s[SBOX_W-2:0], 1'b0} ^ (s[SBOX_W-1] ? GF_RED : 6'h00);
    end
    return p;
  endfunction

  logic [SBOX_W-1:0] x2, x4, x8, x16, x32;

  // Squaring chain followed by the two products
  always_comb begin
    x2  = gf_mul(x, x);
    x4  = gf_mul(x2, x2);
    x8  = gf_mul(x4, x4);
    x16 = gf_mul(x8, x8);
    x32 = gf_mul(x16, x16);
    y   = gf_mul(gf_mul(x32, x16), x4);
  end

endmodule

// File: rtl/sms_sbox_share_arb.sv
// One S-box core shared by N_REQ requesters with round-robin arbitration
// and a single registered, id-tagged result stage.
module sms_sbox_share_arb
  import sms_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [SBOX_W*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  output logic [SBOX_W-1:0]       rsp_data,
  output logic [ID_W-1:0]         rsp_id,
  input  logic                    rsp_ready,
  output logic                    busy
);

  logic [ID_W-1:0]   rr_ptr;
  logic [ID_W-1:0]   gnt_idx;
  logic [N_REQ-1:0]  gnt;
  logic              slot_free;
  logic              xfer;
  logic [SBOX_W-1:0] sbox_in;
  logic [SBOX_W-1:0] sbox_out;

  // Result slot can take a new value when empty or being drained this cycle
  assign slot_free = !rsp_valid || rsp_ready;
  assign req_ready = gnt;
  assign xfer      = |(req_valid & gnt);
  assign busy      = (|req_valid) || rsp_valid;

  sms_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .req    (req_valid),
    .ptr    (rr_ptr),
    .enable (rst_n && slot_free),
    .grant  (gnt),
    .idx    (gnt_idx)
  );

  // Operand mux driven by the granted index
  always_comb begin
    sbox_in = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (gnt_idx == ID_W'(i)) sbox_in = req_data[i*SBOX_W +: SBOX_W];
    end
  end

  sms_sbox_core u_sbox (
    .x (sbox_in),
    .y (sbox_out)
  );

  // Result register and round-robin pointer; a drain without refill only clears valid
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_id    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      rsp_valid <= 1'b1;
      rsp_data  <= sbox_out;
      rsp_id    <= gnt_idx;
      rr_ptr    <= ID_W'(rr_next(32'(gnt_idx), N_REQ));
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sms_sbox_share_arb.sv
// Randomized self-checking bench for sms_sbox_share_arb against a cycle-level
// behavioural model and a per-requester in-order scoreboard.
module tb_sms_sbox_share_arb;
  import sms_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req_valid;
  logic [6*N-1:0]  req_data;
  logic [N-1:0]    req_ready;
  logic            rsp_valid;
  logic [5:0]      rsp_data;
  logic [IW-1:0]   rsp_id;
  logic            rsp_ready;
  logic            busy;

  always #5 clk = ~clk;

  sms_sbox_share_arb #(.N_REQ(N), .ID_W(IW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_ready (rsp_ready),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model state
  bit         m_valid;
  logic [5:0] m_data;
  int         m_id;
  int         m_ptr;
  bit         pend_v [N];
  logic [5:0] pend_d [N];
  logic [5:0] src [N][$];
  logic [5:0] inflight [N][$];
  int         rcv [N];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < int'(N); i++) begin
      req_valid[i]       = pend_v[i];
      req_data[i*6 +: 6] = pend_v[i] ? pend_d[i] : 6'($urandom);
    end
  endtask

  function automatic bit any_pending();
    bit r;
    r = 1'b0;
    for (int i = 0; i < int'(N); i++) r |= pend_v[i];
    return r;
  endfunction

  // One clock: check outputs at negedge against the model, advance the model at posedge
  task automatic cycle();
    int         g;
    int         cand;
    logic [N-1:0] er;
    logic [5:0] obs;
    logic [5:0] e;
    bit         consumed;
    drive();
    @(negedge clk);
    g = -1;
    if (rst_n && (!m_valid || rsp_ready)) begin
      for (int k = 0; k < int'(N); k++) begin
        cand = (m_ptr + k) % int'(N);
        if (g < 0 && req_valid[cand]) g = cand;
      end
    end
    er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
    check_eq("req_ready", 32'(req_ready), 32'(er));
    check_eq("rsp_valid", 32'(rsp_valid), 32'(m_valid));
    check_eq("rsp_data",  32'(rsp_data),  32'(m_data));
    check_eq("rsp_id",    32'(rsp_id),    32'(m_id));
    check_eq("busy",      32'(busy),      32'((|req_valid) || m_valid));
    obs = rsp_data;
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 1'b0;
      m_data  = '0;
      m_id    = 0;
      m_ptr   = 0;
      for (int i = 0; i < int'(N); i++) inflight[i].delete();
    end else begin
      consumed = m_valid && rsp_ready;
      if (consumed) begin
        if (inflight[m_id].size() == 0) begin
          check_eq("sb_unexpected", 32'(inflight[m_id].size()), 32'd1);
        end else begin
          e = inflight[m_id].pop_front();
          check_eq("sb_order", 32'(obs), 32'(SBOX_GOLDEN[e]));
          rcv[m_id]++;
        end
      end
      if (g >= 0) begin
        m_data  = SBOX_GOLDEN[pend_d[g]];
        m_id    = g;
        m_valid = 1'b1;
        m_ptr   = (g + 1) % int'(N);
        inflight[g].push_back(pend_d[g]);
        pend_v[g] = 1'b0;
      end else if (consumed) begin
        m_valid = 1'b0;
      end
    end
    #1;
  endtask

  task automatic drain();
    int b;
    b = 0;
    while ((any_pending() || m_valid) && b < 200) begin
      cycle();
      b++;
    end
    check_eq("drain_timeout", 32'(any_pending() || m_valid), 32'd0);
  endtask

  initial begin
    logic [5:0] perm [64];
    logic [5:0] tmp;
    int         j;
    int         budget;
    bit         done;

    m_valid = 1'b0; m_data = '0; m_id = 0; m_ptr = 0;
    rst_n = 1'b0;
    rsp_ready = 1'b1;
    // Reset with every requester valid, operands 0..3
    for (int i = 0; i < int'(N); i++) begin
      pend_v[i] = 1'b1;
      pend_d[i] = 6'(i);
      rcv[i]    = 0;
    end
    drive();
    @(posedge clk); #1;
    repeat (2) cycle();
    rst_n = 1'b1;

    // Round-robin sweep: keep refilling so ids run 0,1,2,3,0,1,2,3
    for (int r = 0; r < 8; r++) begin
      cycle();
      for (int i = 0; i < int'(N); i++) begin
        if (!pend_v[i] && r < 4) begin
          pend_v[i] = 1'b1;
          pend_d[i] = 6'(i);
        end
      end
    end
    drain();

    // Single request on requester 1 with operand 1
    pend_v[1] = 1'b1;
    pend_d[1] = 6'h01;
    cycle();
    cycle();
    drain();

    // Backpressure: hold a result for 5 cycles with two waiting requesters
    rsp_ready = 1'b0;
    pend_v[0] = 1'b1; pend_d[0] = 6'h05;
    pend_v[3] = 1'b1; pend_d[3] = 6'h29;
    repeat (6) cycle();
    rsp_ready = 1'b1;
    drain();

    // Mid-operation reset while a result is held
    rsp_ready = 1'b0;
    pend_v[2] = 1'b1; pend_d[2] = 6'h07;
    cycle();
    cycle();
    pend_v[3] = 1'b1; pend_d[3] = 6'h3e;
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    cycle();
    rsp_ready = 1'b1;
    drain();

    // Exhaustive: each requester sends all 64 values in a random order
    for (int i = 0; i < int'(N); i++) begin
      rcv[i] = 0;
      for (int v = 0; v < 64; v++) perm[v] = 6'(v);
      for (int v = 63; v > 0; v--) begin
        j = int'($urandom_range(v, 0));
        tmp = perm[v]; perm[v] = perm[j]; perm[j] = tmp;
      end
      src[i].delete();
      for (int v = 0; v < 64; v++) src[i].push_back(perm[v]);
    end
    budget = 0;
    done   = 1'b0;
    while (!done && budget < 5000) begin
      for (int i = 0; i < int'(N); i++) begin
        if (!pend_v[i] && src[i].size() > 0 && ($urandom % 2) == 0) begin
          pend_v[i] = 1'b1;
          pend_d[i] = src[i].pop_front();
        end
      end
      rsp_ready = (($urandom % 4) != 0);
      cycle();
      budget++;
      done = !any_pending() && !m_valid;
      for (int i = 0; i < int'(N); i++) if (src[i].size() > 0) done = 1'b0;
    end
    check_eq("exh_timeout", 32'(done), 32'd1);
    rsp_ready = 1'b1;
    for (int i = 0; i < int'(N); i++) begin
      check_eq($sformatf("exh_count%0d", i), 32'(rcv[i]), 32'd64);
      check_eq($sformatf("exh_left%0d", i), 32'(inflight[i].size()), 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
